// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the fetch-to-decode instruction queue.
// Also holds the pointer helpers used by the queue.
package inst_fetch_queue_pkg;

   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int ILEN  = 32;
   localparam int XLEN  = 32;

   localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

   typedef logic [AW:0] ptr_t;

   typedef struct packed {
      logic [ILEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic            bflag;
   } ifq_entry_t;

   function automatic logic [AW-1:0] ptr_idx(ptr_t p);
      return p[AW-1:0];
   endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Push (fetch) and pop (decode) handshake bundle of the instruction queue.
// The master side is the fetch/issue environment, the slave side the queue.
interface inst_fetch_queue_if;
   import inst_fetch_queue_pkg::*;

   logic            push_vld;
   logic            push_rdy;
   logic [ILEN-1:0] push_inst;
   logic [XLEN-1:0] push_pc;
   logic            push_bflag;

   logic            inst_vld;
   logic [ILEN-1:0] inst;
   logic [XLEN-1:0] pc;
   logic            bpu_bflag;
   logic            pop_rdy;
   logic [AW:0]     count;

   modport master (
      output push_vld, push_inst, push_pc, push_bflag, pop_rdy,
      input  push_rdy, inst_vld, inst, pc, bpu_bflag, count
   );

   modport slave (
      input  push_vld, push_inst, push_pc, push_bflag, pop_rdy,
      output push_rdy, inst_vld, inst, pc, bpu_bflag, count
   );

endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction buffer between fetch/BPU and decode.
// Wrap-bit pointer FIFO; flush on redirect has top priority.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_flush,
   inst_fetch_queue_if.slave    bus
);

   ptr_t       wptr_q, wptr_d;
   ptr_t       rptr_q, rptr_d;
   ifq_entry_t mem_q [DEPTH];
   ifq_entry_t head;

   logic empty;
   logic full;
   logic push;
   logic pop;

   assign empty = (wptr_q == rptr_q);
   assign full  = (ptr_idx(wptr_q) == ptr_idx(rptr_q))
                & (wptr_q[AW] != rptr_q[AW]);

   assign push = bus.push_vld & ~full;
   assign pop  = ~empty & bus.pop_rdy;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (i_flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + ptr_t'(1);
         if (pop)  rptr_d = rptr_q + ptr_t'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage is deliberately left unreset; empty masks stale contents.
   always_ff @(posedge i_clk) begin
      if (push && !i_flush) begin
         mem_q[ptr_idx(wptr_q)] <= '{
            inst:  bus.push_inst,
            pc:    bus.push_pc,
            bflag: bus.push_bflag
         };
      end
   end

   always_comb begin
      head = '{inst: NOP_INST, pc: '0, bflag: 1'b0};
      if (!empty) head = mem_q[ptr_idx(rptr_q)];
   end

   assign bus.push_rdy  = ~full;
   assign bus.inst_vld  = ~empty;
   assign bus.inst      = head.inst;
   assign bus.pc        = head.pc;
   assign bus.bpu_bflag = head.bflag;
   assign bus.count     = wptr_q - rptr_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed plus random bench for inst_fetch_queue.
// Reference model is a plain SV queue of entries.
module tb_inst_fetch_queue;
   import inst_fetch_queue_pkg::*;

   logic i_clk  = 1'b0;
   logic i_rstn = 1'b0;
   logic i_flush = 1'b0;

   inst_fetch_queue_if ifq ();

   inst_fetch_queue dut (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_flush (i_flush),
      .bus     (ifq.slave)
   );

   always #5 i_clk = ~i_clk;

   ifq_entry_t q[$];
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      logic        ev;
      logic [31:0] ei, ep;
      logic        eb;
      ev = (q.size() != 0);
      ei = ev ? q[0].inst : 32'h0000_0013;
      ep = ev ? q[0].pc : 32'h0;
      eb = ev ? q[0].bflag : 1'b0;
      chk({tag, ".vld"}, 32'(ifq.inst_vld), 32'(ev));
      chk({tag, ".inst"}, ifq.inst, ei);
      chk({tag, ".pc"}, ifq.pc, ep);
      chk({tag, ".bflag"}, 32'(ifq.bpu_bflag), 32'(eb));
      chk({tag, ".rdy"}, 32'(ifq.push_rdy), 32'(q.size() < DEPTH));
      chk({tag, ".count"}, 32'(ifq.count), q.size());
   endtask

   task automatic drive(input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic bf,
                        input logic pop, input logic fl);
      ifq.push_vld   = v;
      ifq.push_inst  = ins;
      ifq.push_pc    = pc;
      ifq.push_bflag = bf;
      ifq.pop_rdy    = pop;
      i_flush        = fl;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   // Check current outputs, advance the model, then clock.
   task automatic step(string tag);
      bit do_push, do_pop;
      ifq_entry_t e;
      check_all(tag);
      do_push = ifq.push_vld && (q.size() < DEPTH);
      do_pop  = ifq.pop_rdy && (q.size() > 0);
      e = '{inst: ifq.push_inst, pc: ifq.push_pc, bflag: ifq.push_bflag};
      if (i_flush) begin
         q.delete();
      end else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(e);
      end
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      idle();
      #12;
      check_all("reset");
      i_rstn = 1'b1;
      @(posedge i_clk);
      #1;

      // Directed three-entry push and in-order drain.
      drive(1, 32'h0050_0093, 32'h100, 0, 0, 0); step("t2.p0");
      drive(1, 32'h0010_8113, 32'h104, 0, 0, 0); step("t2.p1");
      drive(1, 32'h0000_0463, 32'h108, 1, 0, 0); step("t2.p2");
      idle();
      chk("t2.count3", 32'(ifq.count), 3);
      chk("t2.head0", ifq.inst, 32'h0050_0093);
      step("t2.hold");
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 1, 0);
         if (i == 2) chk("t2.bflag3", 32'(ifq.bpu_bflag), 1);
         step("t2.pop");
      end
      idle();
      chk("t2.nop", ifq.inst, 32'h0000_0013);
      step("t2.empty");

      // Fill to full; pop while full refuses the push.
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h1000 + 32'(i), 32'h200 + 32'(4 * i), 0, 0, 0);
         step("t3.fill");
      end
      drive(1, 32'h2222, 32'h210, 1, 1, 0);
      chk("t3.full_rdy", 32'(ifq.push_rdy), 0);
      step("t3.full_pop");
      drive(1, 32'h2222, 32'h210, 1, 0, 0);
      chk("t3.count3", 32'(ifq.count), 3);
      step("t3.retry");
      idle();
      step("t3.after");
      while (q.size() > 0) begin
         drive(0, 0, 0, 0, 1, 0);
         step("t3.drain");
      end

      // Streaming push+pop across several pointer wraps.
      for (int i = 0; i < 20; i++) begin
         drive(1, 32'h3000 + 32'(i), 32'h400 + 32'(4 * i), i[0], 1, 0);
         if (i > 0) chk("t4.count1", 32'(ifq.count), 1);
         if (i > 0) chk("t4.pc", ifq.pc, 32'h400 + 32'(4 * (i - 1)));
         step("t4.stream");
      end
      drive(0, 0, 0, 0, 1, 0);
      step("t4.tail");

      // Flush wins over simultaneous push and pop.
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h5000 + 32'(i), 32'h600 + 32'(4 * i), 0, 0, 0);
         step("t5.fill");
      end
      drive(1, 32'hdead_beef, 32'h700, 1, 1, 1);
      step("t5.flush");
      idle();
      chk("t5.count0", 32'(ifq.count), 0);
      step("t5.after");
      step("t5.after2");

      // Pop on empty is ignored; single push visible next cycle.
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 1, 0);
         step("t6.emptypop");
      end
      drive(1, 32'h0000_1117, 32'h800, 0, 0, 0);
      chk("t6.notyet", 32'(ifq.inst_vld), 0);
      step("t6.push");
      idle();
      chk("t6.head", ifq.pc, 32'h800);
      step("t6.visible");

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1), $urandom, $urandom,
               $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 15) == 0));
         step("rnd");
      end

      // Asynchronous reset in the middle of traffic.
      idle();
      while (q.size() < 2) begin
         drive(1, $urandom, $urandom, 0, 0, 0);
         step("t1.fill");
      end
      drive(1, 32'h9999, 32'h900, 1, 1, 0);
      #2;
      i_rstn = 1'b0;
      #1;
      q.delete();
      check_all("t1.reset");
      idle();
      #1;
      i_rstn = 1'b1;
      @(posedge i_clk);
      #1;
      step("t1.post");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
